// File: rtl/mreq_arbiter_rr.sv
// Memory-request arbiter: picks one of REQS_NUM requesters (fixed priority or
// round-robin), captures its fields and holds them until the downstream
// completes the request.
module mreq_arbiter_rr #(
  parameter int REQS_NUM     = 2,
  parameter int REQS_IBITS   = 1,
  parameter int MODE         = 1,
  parameter int WCOUNT_WIDTH = 8,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [REQS_NUM-1:0]     i_mreqs_valid,
  output logic [REQS_NUM-1:0]     o_mreqs_ready,
  output logic [REQS_IBITS-1:0]   o_mreq_sel,
  input  logic                    i_mreq_wr,
  input  logic                    i_mreq_aincr,
  input  logic [1:0]              i_mreq_wsize,
  input  logic [WCOUNT_WIDTH-1:0] i_mreq_wcount,
  input  logic [ADDR_WIDTH-1:0]   i_mreq_addr,
  output logic                    o_mreq_valid,
  input  logic                    i_mreq_ready,
  output logic                    o_mreq_wr,
  output logic                    o_mreq_aincr,
  output logic [1:0]              o_mreq_wsize,
  output logic [WCOUNT_WIDTH-1:0] o_mreq_wcount,
  output logic [ADDR_WIDTH-1:0]   o_mreq_addr,
  output logic                    o_busy
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                  state_q, state_d;
  logic [REQS_IBITS-1:0]   grant_q, grant_d;
  logic [REQS_IBITS-1:0]   last_q, last_d;
  logic                    wr_q, wr_d;
  logic                    aincr_q, aincr_d;
  logic [1:0]              wsize_q, wsize_d;
  logic [WCOUNT_WIDTH-1:0] wcount_q, wcount_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

  logic [REQS_IBITS-1:0]   winner;
  logic                    any_valid;
  int                      idx;

  // Round-robin scans downward so the closest index after last_q is written last and wins.
  always_comb begin
    winner    = '0;
    idx       = 0;
    any_valid = |i_mreqs_valid;
    if (MODE == 0) begin
      for (int i = 0; i < REQS_NUM; i++) begin
        if (i_mreqs_valid[i]) winner = REQS_IBITS'(i);
      end
    end else begin
      for (int k = REQS_NUM; k >= 1; k--) begin
        idx = int'(last_q) + k;
        if (idx >= REQS_NUM) idx = idx - REQS_NUM;
        if (i_mreqs_valid[idx]) winner = REQS_IBITS'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wr_d     = wr_q;
    aincr_d  = aincr_q;
    wsize_d  = wsize_q;
    wcount_d = wcount_q;
    addr_d   = addr_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d  = EXEC;
          grant_d  = winner;
          if (MODE == 1) last_d = winner;
          wr_d     = i_mreq_wr;
          aincr_d  = i_mreq_aincr;
          wsize_d  = i_mreq_wsize;
          wcount_d = i_mreq_wcount;
          addr_d   = i_mreq_addr;
        end
      end
      EXEC: begin
        if (i_mreq_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= REQS_IBITS'(REQS_NUM - 1);
      wr_q     <= 1'b0;
      aincr_q  <= 1'b0;
      wsize_q  <= '0;
      wcount_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wr_q     <= wr_d;
      aincr_q  <= aincr_d;
      wsize_q  <= wsize_d;
      wcount_q <= wcount_d;
      addr_q   <= addr_d;
    end
  end

  // The completion strobe is combinational so the requester sees it in the same cycle as i_mreq_ready.
  always_comb begin
    o_mreqs_ready = '0;
    for (int i = 0; i < REQS_NUM; i++) begin
      o_mreqs_ready[i] = (state_q == EXEC) && i_mreq_ready && (grant_q == REQS_IBITS'(i));
    end
  end

  assign o_mreq_sel    = ((state_q == IDLE) && any_valid) ? winner : grant_q;
  assign o_mreq_valid  = (state_q == EXEC);
  assign o_busy        = (state_q == EXEC);
  assign o_mreq_wr     = wr_q;
  assign o_mreq_aincr  = aincr_q;
  assign o_mreq_wsize  = wsize_q;
  assign o_mreq_wcount = wcount_q;
  assign o_mreq_addr   = addr_q;

endmodule

// File: tb/tb_mreq_arbiter_rr.sv
// Bench for mreq_arbiter_rr: a round-robin and a fixed-priority instance share
// inputs and are compared every cycle against a transaction-level model.
module tb_mreq_arbiter_rr;

  localparam int N  = 3;
  localparam int IB = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  valid_in;
  logic          ready_in;

  logic          req_wr     [4];
  logic          req_aincr  [4];
  logic [1:0]    req_wsize  [4];
  logic [7:0]    req_wcount [4];
  logic [31:0]   req_addr   [4];

  logic [N-1:0]  rr_rdy, fp_rdy;
  logic [IB-1:0] rr_sel, fp_sel;
  logic          rr_valid, fp_valid, rr_busy, fp_busy;
  logic          rr_wr, fp_wr, rr_aincr, fp_aincr;
  logic [1:0]    rr_wsize, fp_wsize;
  logic [7:0]    rr_wcount, fp_wcount;
  logic [31:0]   rr_addr, fp_addr;

  int            check_count;
  int            error_count;

  // Per-instance model: index 0 is round-robin, index 1 is fixed priority.
  logic          m_busy   [2];
  int            m_grant  [2];
  int            m_last   [2];
  logic          m_wr     [2];
  logic          m_aincr  [2];
  logic [1:0]    m_wsize  [2];
  logic [7:0]    m_wcount [2];
  logic [31:0]   m_addr   [2];

  mreq_arbiter_rr #(.REQS_NUM(N), .REQS_IBITS(IB), .MODE(1), .WCOUNT_WIDTH(8), .ADDR_WIDTH(32)) dut_rr (
    .i_clk(clk), .i_rst(rst), .i_mreqs_valid(valid_in), .o_mreqs_ready(rr_rdy), .o_mreq_sel(rr_sel),
    .i_mreq_wr(req_wr[rr_sel]), .i_mreq_aincr(req_aincr[rr_sel]), .i_mreq_wsize(req_wsize[rr_sel]),
    .i_mreq_wcount(req_wcount[rr_sel]), .i_mreq_addr(req_addr[rr_sel]),
    .o_mreq_valid(rr_valid), .i_mreq_ready(ready_in),
    .o_mreq_wr(rr_wr), .o_mreq_aincr(rr_aincr), .o_mreq_wsize(rr_wsize),
    .o_mreq_wcount(rr_wcount), .o_mreq_addr(rr_addr), .o_busy(rr_busy)
  );

  mreq_arbiter_rr #(.REQS_NUM(N), .REQS_IBITS(IB), .MODE(0), .WCOUNT_WIDTH(8), .ADDR_WIDTH(32)) dut_fp (
    .i_clk(clk), .i_rst(rst), .i_mreqs_valid(valid_in), .o_mreqs_ready(fp_rdy), .o_mreq_sel(fp_sel),
    .i_mreq_wr(req_wr[fp_sel]), .i_mreq_aincr(req_aincr[fp_sel]), .i_mreq_wsize(req_wsize[fp_sel]),
    .i_mreq_wcount(req_wcount[fp_sel]), .i_mreq_addr(req_addr[fp_sel]),
    .o_mreq_valid(fp_valid), .i_mreq_ready(ready_in),
    .o_mreq_wr(fp_wr), .o_mreq_aincr(fp_aincr), .o_mreq_wsize(fp_wsize),
    .o_mreq_wcount(fp_wcount), .o_mreq_addr(fp_addr), .o_busy(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Winner straight from the rules: fixed = highest asserted, RR = first asserted after last.
  function automatic int modelWinner(input int rr, input int last, input logic [N-1:0] v);
    int w;
    w = -1;
    if (rr == 0) begin
      for (int i = 0; i < N; i++) if (v[i]) w = i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (w < 0 && v[(last + k) % N]) w = (last + k) % N;
      end
    end
    return w;
  endfunction

  task automatic resetModels();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0; m_grant[d] = 0; m_last[d] = N - 1;
      m_wr[d] = 1'b0; m_aincr[d] = 1'b0; m_wsize[d] = '0; m_wcount[d] = '0; m_addr[d] = '0;
    end
  endtask

  task automatic updateModels();
    int w;
    if (rst) begin
      resetModels();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (m_busy[d]) begin
        if (ready_in) m_busy[d] = 1'b0;
      end else begin
        w = modelWinner(d == 0 ? 1 : 0, m_last[d], valid_in);
        if (w >= 0) begin
          m_busy[d] = 1'b1; m_grant[d] = w;
          if (d == 0) m_last[d] = w;
          m_wr[d] = req_wr[w]; m_aincr[d] = req_aincr[w]; m_wsize[d] = req_wsize[w];
          m_wcount[d] = req_wcount[w]; m_addr[d] = req_addr[w];
        end
      end
    end
  endtask

  task automatic checkDut(input int d, input string nm, input logic [IB-1:0] sel, input logic [N-1:0] rdy,
                          input logic vld, input logic bsy, input logic wr, input logic aincr,
                          input logic [1:0] wsize, input logic [7:0] wcount, input logic [31:0] addr);
    int w, exp_sel;
    logic [N-1:0] exp_rdy;
    w = modelWinner(d == 0 ? 1 : 0, m_last[d], valid_in);
    exp_sel = (!m_busy[d] && w >= 0) ? w : m_grant[d];
    exp_rdy = (m_busy[d] && ready_in && !rst) ? N'(1 << m_grant[d]) : '0;
    checkOutput({nm, "_sel"},    64'(sel),    64'(exp_sel));
    checkOutput({nm, "_ready"},  64'(rdy),    64'(exp_rdy));
    checkOutput({nm, "_valid"},  64'(vld),    64'(m_busy[d]));
    checkOutput({nm, "_busy"},   64'(bsy),    64'(m_busy[d]));
    checkOutput({nm, "_wr"},     64'(wr),     64'(m_wr[d]));
    checkOutput({nm, "_aincr"},  64'(aincr),  64'(m_aincr[d]));
    checkOutput({nm, "_wsize"},  64'(wsize),  64'(m_wsize[d]));
    checkOutput({nm, "_wcount"}, 64'(wcount), 64'(m_wcount[d]));
    checkOutput({nm, "_addr"},   64'(addr),   64'(m_addr[d]));
  endtask

  // Inputs are already set at the falling edge; check, clock, advance the model.
  task automatic stepCycle(input int exp_rr_rdy, input int exp_fp_rdy);
    #1;
    checkDut(0, "rr", rr_sel, rr_rdy, rr_valid, rr_busy, rr_wr, rr_aincr, rr_wsize, rr_wcount, rr_addr);
    checkDut(1, "fp", fp_sel, fp_rdy, fp_valid, fp_busy, fp_wr, fp_aincr, fp_wsize, fp_wcount, fp_addr);
    if (exp_rr_rdy >= 0) checkOutput("rr_ready_seq", 64'(rr_rdy), 64'(exp_rr_rdy));
    if (exp_fp_rdy >= 0) checkOutput("fp_ready_seq", 64'(fp_rdy), 64'(exp_fp_rdy));
    @(posedge clk);
    updateModels();
    @(negedge clk);
  endtask

  task automatic randomizeFields();
    for (int i = 0; i < N; i++) begin
      req_wr[i] = 1'($urandom); req_aincr[i] = 1'($urandom); req_wsize[i] = 2'($urandom);
      req_wcount[i] = 8'($urandom); req_addr[i] = $urandom;
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    resetModels();
    stepCycle(-1, -1);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int ready_pct);
    randomizeFields();
    valid_in = N'($urandom);
    ready_in = ($urandom_range(99) < 32'(ready_pct));
  endtask

  int rr_seq[8] = '{0, 1, 0, 2, 0, 4, 0, 1};
  int fp_seq[6] = '{0, 2, 0, 2, 0, 2};

  initial begin
    check_count = 0;
    error_count = 0;
    rst = 1'b1; valid_in = '0; ready_in = 1'b0;
    req_wr[3] = 1'b0; req_aincr[3] = 1'b0; req_wsize[3] = '0; req_wcount[3] = '0; req_addr[3] = '0;
    randomizeFields();
    resetModels();
    @(negedge clk);

    // All three requesting with immediate completion: RR rotates, fixed picks 2.
    applyReset();
    valid_in = 3'b111; ready_in = 1'b1;
    for (int c = 0; c < 8; c++) begin
      randomizeFields();
      stepCycle(rr_seq[c], (c % 2 == 1) ? 4 : 0);
    end

    // Fixed priority with 0 and 1 asserted never serves 0.
    applyReset();
    valid_in = 3'b011; ready_in = 1'b1;
    for (int c = 0; c < 6; c++) stepCycle(-1, fp_seq[c]);

    // Single request, then field toggling and valid drop during EXEC.
    applyReset();
    valid_in = 3'b010; ready_in = 1'b0;
    req_addr[1] = 32'h12345678; req_wcount[1] = 8'h10; req_wr[1] = 1'b1;
    stepCycle(0, 0);
    valid_in = 3'b000; req_addr[1] = 32'hDEADBEEF;
    #1;
    checkOutput("single_addr", 64'(rr_addr), 64'h12345678);
    checkOutput("single_wcount", 64'(rr_wcount), 64'h10);
    checkOutput("single_wr", 64'(rr_wr), 64'h1);
    stepCycle(0, 0);
    ready_in = 1'b1;
    stepCycle(3'b010, 3'b010);
    stepCycle(0, 0);

    // Reset in EXEC abandons the request; RR search restarts at 0.
    valid_in = 3'b111; ready_in = 1'b0;
    stepCycle(-1, -1);
    ready_in = 1'b1; rst = 1'b1;
    #1;
    checkOutput("rst_valid", 64'(rr_valid), 64'h0);
    checkOutput("rst_ready", 64'(rr_rdy), 64'h0);
    resetModels();
    stepCycle(0, 0);
    rst = 1'b0; valid_in = 3'b100; ready_in = 1'b0;
    stepCycle(0, 0);
    checkOutput("rst_regrant", 64'(rr_sel), 64'h2);

    // Downstream stalls for 50 cycles while inputs keep moving.
    for (int c = 0; c < 50; c++) begin
      applyStimulus(0);
      stepCycle(0, 0);
      checkOutput("stall_busy", 64'(rr_busy), 64'h1);
    end
    ready_in = 1'b1;
    stepCycle(3'b100, -1);

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      applyStimulus(40);
      if ($urandom_range(59) == 0) rst = 1'b1;
      if (rst) resetModels();
      stepCycle(-1, -1);
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/mreq_arbiter_rr.md
MREQ_ARBITER_RR -- requirements
Module: mreq_arbiter_rr

Interface
REQ-001 SHALL have parameter REQS_NUM, default 2: number of MREQ requesters, 1..16.
REQ-002 SHALL have parameter REQS_IBITS, default 1: grant index width; 2^REQS_IBITS >= REQS_NUM.
REQ-003 SHALL have parameter MODE, default 1: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-004 SHALL have parameter WCOUNT_WIDTH, default 8: word-count field width.
REQ-005 SHALL have parameter ADDR_WIDTH, default 32: address field width.
REQ-006 Clocking: one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port i_clk  in  1  the single clock.
REQ-008 SHALL have port i_rst  in  1  asynchronous active-high reset.
REQ-009 SHALL have port i_mreqs_valid  in  REQS_NUM  per-requester request pending.
REQ-010 SHALL have port o_mreqs_ready  out  REQS_NUM  per-requester completion strobe.
REQ-011 SHALL have port o_mreq_sel  out  REQS_IBITS  index steering the external field mux.
REQ-012 SHALL have ports i_mreq_wr/i_mreq_aincr (1), i_mreq_wsize (2), i_mreq_wcount (WCOUNT_WIDTH), i_mreq_addr (ADDR_WIDTH), all in: muxed fields of the requester at o_mreq_sel.
REQ-013 SHALL have port o_mreq_valid  out  1  captured request offered downstream.
REQ-014 SHALL have port i_mreq_ready  in  1  downstream completed the request.
REQ-015 SHALL have ports o_mreq_wr, o_mreq_aincr, o_mreq_wsize, o_mreq_wcount, o_mreq_addr, all out, widths as REQ-012: registered request fields.
REQ-016 SHALL have port o_busy  out  1  high in EXEC state.

Function
REQ-017 State machine SHALL have two states: IDLE and EXEC.
REQ-018 IDLE: o_mreq_sel SHALL equal the combinational winner among asserted i_mreqs_valid; if none are asserted, it SHALL hold the last grant.
REQ-019 MODE 0: the winner SHALL be the highest asserted index.
REQ-020 MODE 1: the winner SHALL be the first asserted index searching upward from last_grant+1, wrapping at REQS_NUM-1 to 0.
REQ-021 IDLE with any valid asserted: at the clock edge, fields SHALL be captured from i_mreq_*, grant SHALL be registered, last_grant SHALL update (MODE 1), and the FSM SHALL go to EXEC; this costs 1 cycle of latency from valid to o_mreq_valid.
REQ-022 EXEC: o_mreq_valid=1, o_busy=1, o_mreq_sel=registered grant; fields SHALL stay stable.
REQ-023 EXEC with i_mreq_ready=1: o_mreqs_ready[grant]=1 that same cycle (combinational); the FSM SHALL return to IDLE at the edge.
REQ-024 o_mreqs_ready SHALL be one-hot or zero, and SHALL be nonzero only under REQ-023.
REQ-025 A requester that deasserts valid during EXEC SHALL NOT cancel its request; the request completes normally.
REQ-026 Requests arriving during EXEC SHALL wait; they are arbitrated only in IDLE.
REQ-027 Back-to-back: there SHALL be a minimum 1-cycle IDLE gap between consecutive grants.
REQ-028 i_mreq_ready in IDLE SHALL be ignored.
REQ-029 REQS_NUM=1: the arbiter SHALL degenerate to a register slice; o_mreq_sel SHALL be constantly 0.
REQ-030 Indices >= REQS_NUM SHALL never be granted.

Reset
REQ-031 On i_rst, asynchronously: state=IDLE; o_mreq_valid, o_busy, o_mreqs_ready, and all o_mreq_* fields SHALL be 0; registered grant SHALL be 0; last_grant SHALL be REQS_NUM-1, so the first RR search starts at 0.
REQ-032 Reset asserted in EXEC SHALL abandon the request with no ready strobe; after release, the requester is re-arbitrated if still valid.

Verification
REQ-033 MODE 1, REQS_NUM=3, valid=3'b111 held, i_mreq_ready=1 in each EXEC -> grants 0,1,2,0, each with one ready pulse, gap of 1 IDLE cycle.
REQ-034 MODE 0, REQS_NUM=3, valid=3'b011 held -> grant 1 repeatedly; index 0 is never served while 1 is asserted.
REQ-035 Single request: index 1 presents addr=0x12345678, wcount=8'h10, wr=1 -> next cycle o_mreq_valid=1 with identical fields; o_mreqs_ready=3'b010 only in the ready cycle.
REQ-036 During EXEC, toggle i_mreq_addr and drop the granted valid -> o_mreq_addr is unchanged and the request still completes with its ready pulse.
REQ-037 Assert i_rst mid-EXEC -> o_mreq_valid falls immediately with no ready pulse; after release with valid=3'b100 in MODE 1, the grant is 2 (search from 0).
REQ-038 i_mreq_ready held low for 50 cycles in EXEC -> all outputs stable and o_busy=1 throughout.
